// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave transfer engine.
package spi_pkg;

   localparam int DATA_W_DEF = 8;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   // Edge selection: cpol gives the SCK idle level, cpha picks the sampling edge
   localparam logic CPOL_IDLE_LOW       = 1'b0;
   localparam logic CPHA_SAMPLE_LEADING = 1'b0;

   // Bit positions of the pad signals inside the shared synchronizer
   localparam int SYNC_SCK  = 0;
   localparam int SYNC_MOSI = 1;
   localparam int SYNC_SSN  = 2;
   localparam logic [2:0] SYNC_RST_VAL = 3'b100;

endpackage

// File: rtl/spi_sync.sv
// N-flop synchronizer for a bundle of asynchronous pad inputs, per-bit reset value.
module spi_sync #(
   parameter int             W       = 1,
   parameter int             N       = 2,
   parameter logic [W-1:0]   RST_VAL = {W{1'b0}}
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] stage_r [N];

   // shift the pad values through the flop chain
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N; i++) begin
            stage_r[i] <= RST_VAL;
         end
      end else begin
         stage_r[0] <= d;
         for (int i = 1; i < N; i++) begin
            stage_r[i] <= stage_r[i-1];
         end
      end
   end

   assign q = stage_r[N-1];

endmodule

// File: rtl/spi_slave_core.sv
// SPI slave transfer engine: synchronizes pad SCK/MOSI/SS_n, shifts frames in
// and out in any cpol/cpha/bit-order mode, and hands bytes to the register block.
module spi_slave_core
   import spi_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              spe,
   input  logic              mstr,
   input  logic              cpol,
   input  logic              cpha,
   input  logic              lsbfe,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_load,
   input  logic              rx_read,
   input  logic              sck_in,
   input  logic              mosi_in,
   input  logic              ss_n_in,
   output logic              miso_out,
   output logic              miso_oe,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_full,
   output logic              rx_ovf,
   output logic              tx_empty,
   output logic              busy
);

   localparam int CNT_W  = $clog2(DATA_W + 1);
   localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

   function automatic logic first_bit(input logic [DATA_W-1:0] v, input logic lsb);
      if (lsb) begin
         return v[0];
      end else begin
         return v[DATA_W-1];
      end
   endfunction

   function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] v, input logic lsb);
      if (lsb) begin
         return {1'b0, v[DATA_W-1:1]};
      end else begin
         return {v[DATA_W-2:0], 1'b0};
      end
   endfunction

   function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] v, input logic b,
                                                  input logic lsb);
      if (lsb) begin
         return {b, v[DATA_W-1:1]};
      end else begin
         return {v[DATA_W-2:0], b};
      end
   endfunction

   logic [2:0]        pad_s, sync_s;
   logic              sck_s, mosi_s, ssn_s;
   logic              sck_d_r, ssn_d_r;
   state_t            state_r;
   logic              cpol_r, cpha_r, lsbfe_r;
   logic [DATA_W-1:0] tx_sr_r, rx_sr_r, tx_buf_r, rx_data_r;
   logic [CNT_W-1:0]  bit_cnt_r;
   logic              done_r, busy_r, miso_r, miso_oe_r;
   logic              tx_empty_r, rx_full_r, rx_ovf_r;

   logic              enabled_s, oe_next_s, abort_s;
   logic              sck_rise_s, sck_fall_s, lead_s, trail_s, sample_s, shift_s;
   logic              ss_fall_s, start_s, reload_s, load_s;
   logic              ld_cpha_s, ld_lsbfe_s;
   logic [DATA_W-1:0] load_byte_s, ld_sr_s;
   logic              ld_miso_s;

   assign pad_s[SYNC_SCK]  = sck_in;
   assign pad_s[SYNC_MOSI] = mosi_in;
   assign pad_s[SYNC_SSN]  = ss_n_in;

   spi_sync #(
      .W       (3),
      .N       (SYNC_N),
      .RST_VAL (SYNC_RST_VAL)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (pad_s),
      .q   (sync_s)
   );

   assign sck_s  = sync_s[SYNC_SCK];
   assign mosi_s = sync_s[SYNC_MOSI];
   assign ssn_s  = sync_s[SYNC_SSN];

   assign enabled_s  = spe & ~mstr;
   assign oe_next_s  = enabled_s & ~ssn_s;
   assign abort_s    = ssn_s | ~enabled_s;
   assign sck_rise_s = sck_s & ~sck_d_r;
   assign sck_fall_s = ~sck_s & sck_d_r;
   assign lead_s     = (cpol_r == CPOL_IDLE_LOW) ? sck_rise_s : sck_fall_s;
   assign trail_s    = (cpol_r == CPOL_IDLE_LOW) ? sck_fall_s : sck_rise_s;
   assign sample_s   = (cpha_r == CPHA_SAMPLE_LEADING) ? lead_s : trail_s;
   assign shift_s    = (cpha_r == CPHA_SAMPLE_LEADING) ? trail_s : lead_s;
   assign ss_fall_s  = ~ssn_s & ssn_d_r;
   assign start_s    = (state_r == IDLE) & ss_fall_s & enabled_s;
   assign reload_s   = (state_r == ACTIVE) & ~abort_s & done_r;
   assign load_s     = start_s | reload_s;

   // Frame load: a fresh frame takes the live mode bits, a reload keeps the captured ones
   always_comb begin
      ld_cpha_s   = cpha_r;
      ld_lsbfe_s  = lsbfe_r;
      load_byte_s = tx_buf_r;
      if (start_s) begin
         ld_cpha_s  = cpha;
         ld_lsbfe_s = lsbfe;
      end else begin
         ld_cpha_s  = cpha_r;
         ld_lsbfe_s = lsbfe_r;
      end
      if (tx_empty_r) begin
         load_byte_s = {DATA_W{1'b0}};
      end else begin
         load_byte_s = tx_buf_r;
      end
      // cpha=0 puts the first bit out immediately; cpha=1 waits for the first leading edge
      if (ld_cpha_s == CPHA_SAMPLE_LEADING) begin
         ld_sr_s   = shift_out(load_byte_s, ld_lsbfe_s);
         ld_miso_s = first_bit(load_byte_s, ld_lsbfe_s);
      end else begin
         ld_sr_s   = load_byte_s;
         ld_miso_s = 1'b0;
      end
   end

   // previous synced values for edge detection
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sck_d_r <= 1'b0;
         ssn_d_r <= 1'b1;
      end else begin
         sck_d_r <= sck_s;
         ssn_d_r <= ssn_s;
      end
   end

   // frame state machine with shift registers and serial output
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r   <= IDLE;
         cpol_r    <= 1'b0;
         cpha_r    <= 1'b0;
         lsbfe_r   <= 1'b0;
         tx_sr_r   <= {DATA_W{1'b0}};
         rx_sr_r   <= {DATA_W{1'b0}};
         bit_cnt_r <= {CNT_W{1'b0}};
         done_r    <= 1'b0;
         busy_r    <= 1'b0;
         miso_r    <= 1'b0;
         miso_oe_r <= 1'b0;
      end else begin
         done_r    <= 1'b0;
         miso_oe_r <= oe_next_s;
         case (state_r)
            IDLE: begin
               bit_cnt_r <= {CNT_W{1'b0}};
               busy_r    <= 1'b0;
               if (start_s) begin
                  state_r <= ACTIVE;
                  cpol_r  <= cpol;
                  cpha_r  <= cpha;
                  lsbfe_r <= lsbfe;
                  busy_r  <= 1'b1;
                  tx_sr_r <= ld_sr_s;
                  rx_sr_r <= {DATA_W{1'b0}};
                  miso_r  <= ld_miso_s;
               end
            end
            ACTIVE: begin
               if (abort_s) begin
                  state_r   <= IDLE;
                  bit_cnt_r <= {CNT_W{1'b0}};
                  busy_r    <= 1'b0;
               end else if (done_r) begin
                  bit_cnt_r <= {CNT_W{1'b0}};
                  tx_sr_r   <= ld_sr_s;
                  rx_sr_r   <= {DATA_W{1'b0}};
                  miso_r    <= ld_miso_s;
               end else if (sample_s) begin
                  rx_sr_r   <= shift_in(rx_sr_r, mosi_s, lsbfe_r);
                  bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                  if (bit_cnt_r == CNT_W'(DATA_W - 1)) begin
                     done_r <= 1'b1;
                  end
               // in cpha=0 the trailing edge that closes a frame arrives after the reload
               end else if (shift_s && !((cpha_r == CPHA_SAMPLE_LEADING) &&
                                         (bit_cnt_r == {CNT_W{1'b0}}))) begin
                  miso_r  <= first_bit(tx_sr_r, lsbfe_r);
                  tx_sr_r <= shift_out(tx_sr_r, lsbfe_r);
               end
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
            end
         endcase
         if (!oe_next_s) begin
            miso_r <= 1'b0;
         end
      end
   end

   // one-deep transmit buffer
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_buf_r   <= {DATA_W{1'b0}};
         tx_empty_r <= 1'b1;
      end else begin
         if (tx_load) begin
            tx_buf_r   <= tx_data;
            tx_empty_r <= 1'b0;
         end else if (load_s) begin
            tx_empty_r <= 1'b1;
         end
      end
   end

   // receive hand-off; a completing frame beats a coincident host read
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_data_r <= {DATA_W{1'b0}};
         rx_full_r <= 1'b0;
         rx_ovf_r  <= 1'b0;
      end else begin
         if (done_r) begin
            if (!rx_full_r || rx_read) begin
               rx_data_r <= rx_sr_r;
               rx_full_r <= 1'b1;
            end else begin
               rx_ovf_r <= 1'b1;
            end
         end else if (rx_read) begin
            rx_full_r <= 1'b0;
         end
         if (!spe) begin
            rx_ovf_r <= 1'b0;
         end
      end
   end

   assign miso_out = miso_r;
   assign miso_oe  = miso_oe_r;
   assign rx_data  = rx_data_r;
   assign rx_full  = rx_full_r;
   assign rx_ovf   = rx_ovf_r;
   assign tx_empty = tx_empty_r;
   assign busy     = busy_r;

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench for spi_slave_core: the bench acts as SPI master at SCK = clk/8.
module tb_spi_slave_core;

   logic       clk = 1'b0;
   logic       rst, spe, mstr, cpol, cpha, lsbfe, tx_load, rx_read;
   logic       sck_in, mosi_in, ss_n_in;
   logic [7:0] tx_data, rx_data;
   logic       miso_out, miso_oe, rx_full, rx_ovf, tx_empty, busy;
   logic [7:0] mi, mi2;
   int         n_checks = 0;
   int         n_errors = 0;

   always #5 clk = ~clk;

   spi_slave_core #(.DATA_W(8), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .spe(spe), .mstr(mstr), .cpol(cpol), .cpha(cpha),
      .lsbfe(lsbfe), .tx_data(tx_data), .tx_load(tx_load), .rx_read(rx_read),
      .sck_in(sck_in), .mosi_in(mosi_in), .ss_n_in(ss_n_in), .miso_out(miso_out),
      .miso_oe(miso_oe), .rx_data(rx_data), .rx_full(rx_full), .rx_ovf(rx_ovf),
      .tx_empty(tx_empty), .busy(busy)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic load_tx(input logic [7:0] v);
      tx_data = v;
      tx_load = 1'b1;
      tick(1);
      tx_load = 1'b0;
      tick(1);
   endtask

   task automatic rd_pulse();
      rx_read = 1'b1;
      tick(1);
      rx_read = 1'b0;
      tick(1);
   endtask

   // drop ss_n; optionally strobe tx_load exactly in the slave's load cycle
   task automatic ss_low(input logic ld, input logic [7:0] v);
      ss_n_in = 1'b0;
      if (ld) begin
         tick(2);
         tx_data = v;
         tx_load = 1'b1;
         tick(1);
         tx_load = 1'b0;
         tick(1);
      end else begin
         tick(4);
      end
   endtask

   task automatic ss_high();
      ss_n_in = 1'b1;
      tick(4);
   endtask

   // master side of one frame; mi collects MISO in bit-position order
   task automatic frame(input logic [7:0] mo, input int nbits, input logic rd_end,
                        output logic [7:0] mi_o);
      mi_o = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         int idx;
         idx = lsbfe ? i : 7 - i;
         if (!cpha) begin
            mosi_in = mo[idx];
            tick(4);
            mi_o[idx] = miso_out;
            sck_in = ~cpol;
            if (rd_end && i == nbits - 1) begin
               tick(3);
               rx_read = 1'b1;
               tick(1);
               rx_read = 1'b0;
            end else begin
               tick(4);
            end
            sck_in = cpol;
         end else begin
            tick(4);
            sck_in  = ~cpol;
            mosi_in = mo[idx];
            tick(4);
            mi_o[idx] = miso_out;
            sck_in = cpol;
         end
      end
      tick(4);
   endtask

   initial begin
      rst = 1'b0; spe = 1'b0; mstr = 1'b0; cpol = 1'b0; cpha = 1'b0; lsbfe = 1'b0;
      tx_data = 8'h00; tx_load = 1'b0; rx_read = 1'b0;
      sck_in = 1'b0; mosi_in = 1'b0; ss_n_in = 1'b1;
      tick(3);
      check_val("rst_miso", miso_out, 1'b0);
      check_val("rst_oe", miso_oe, 1'b0);
      check_val("rst_rx_data", rx_data, 8'h00);
      check_val("rst_rx_full", rx_full, 1'b0);
      check_val("rst_rx_ovf", rx_ovf, 1'b0);
      check_val("rst_tx_empty", tx_empty, 1'b1);
      check_val("rst_busy", busy, 1'b0);
      rst = 1'b1;
      spe = 1'b1;
      tick(4);

      // mode 0, MSB first
      load_tx(8'hA5);
      check_val("m0_tx_loaded", tx_empty, 1'b0);
      ss_low(1'b0, 8'h00);
      check_val("m0_tx_empty", tx_empty, 1'b1);
      check_val("m0_busy", busy, 1'b1);
      check_val("m0_oe", miso_oe, 1'b1);
      frame(8'h3C, 8, 1'b0, mi);
      ss_high();
      check_val("m0_miso", mi, 8'hA5);
      check_val("m0_rx_data", rx_data, 8'h3C);
      check_val("m0_rx_full", rx_full, 1'b1);
      check_val("m0_busy_end", busy, 1'b0);
      check_val("m0_oe_end", miso_oe, 1'b0);
      rd_pulse();
      check_val("m0_read", rx_full, 1'b0);

      // mode 3, LSB first
      cpol = 1'b1; cpha = 1'b1; lsbfe = 1'b1; sck_in = 1'b1;
      tick(4);
      load_tx(8'h81);
      ss_low(1'b0, 8'h00);
      frame(8'h0F, 8, 1'b0, mi);
      ss_high();
      check_val("m3_miso", mi, 8'h81);
      check_val("m3_rx_data", rx_data, 8'h0F);
      rd_pulse();

      // back-to-back frames with nothing read: overrun
      cpol = 1'b0; cpha = 1'b0; lsbfe = 1'b0; sck_in = 1'b0;
      tick(4);
      ss_low(1'b0, 8'h00);
      frame(8'h11, 8, 1'b0, mi);
      frame(8'h22, 8, 1'b0, mi2);
      ss_high();
      check_val("b2b_miso1", mi, 8'h00);
      check_val("b2b_miso2", mi2, 8'h00);
      check_val("b2b_rx_data", rx_data, 8'h11);
      check_val("b2b_ovf", rx_ovf, 1'b1);
      rd_pulse();
      check_val("b2b_read", rx_full, 1'b0);

      // abort after 5 sample edges, then a clean frame
      ss_low(1'b0, 8'h00);
      frame(8'hFF, 5, 1'b0, mi);
      ss_high();
      check_val("abort_busy", busy, 1'b0);
      check_val("abort_rx_full", rx_full, 1'b0);
      load_tx(8'hC3);
      ss_low(1'b0, 8'h00);
      frame(8'h5A, 8, 1'b0, mi);
      ss_high();
      check_val("post_abort_rx", rx_data, 8'h5A);
      check_val("post_abort_full", rx_full, 1'b1);
      check_val("post_abort_miso", mi, 8'hC3);
      rd_pulse();
      check_val("ovf_sticky", rx_ovf, 1'b1);

      // master mode: slave stays silent
      mstr = 1'b1;
      ss_low(1'b0, 8'h00);
      check_val("mstr_oe", miso_oe, 1'b0);
      check_val("mstr_busy", busy, 1'b0);
      frame(8'hFF, 8, 1'b0, mi);
      ss_high();
      check_val("mstr_rx_full", rx_full, 1'b0);
      check_val("mstr_ovf_kept", rx_ovf, 1'b1);
      mstr = 1'b0;
      tick(2);

      // spe drop mid-frame aborts and clears the overrun flag
      ss_low(1'b0, 8'h00);
      check_val("spe_busy", busy, 1'b1);
      frame(8'hAA, 3, 1'b0, mi);
      spe = 1'b0;
      tick(4);
      check_val("spe_abort_busy", busy, 1'b0);
      check_val("spe_ovf_clr", rx_ovf, 1'b0);
      check_val("spe_oe", miso_oe, 1'b0);
      frame(8'hFF, 8, 1'b0, mi);
      check_val("spe_rx_full", rx_full, 1'b0);
      ss_high();
      spe = 1'b1;
      tick(4);

      // tx_load in the load cycle, then read coincident with completion
      check_val("coin_tx_empty0", tx_empty, 1'b1);
      ss_low(1'b1, 8'h77);
      check_val("coin_tx_pending", tx_empty, 1'b0);
      frame(8'h96, 8, 1'b0, mi);
      check_val("coin_rx1", rx_data, 8'h96);
      frame(8'h4B, 8, 1'b1, mi2);
      ss_high();
      check_val("coin_miso1", mi, 8'h00);
      check_val("coin_miso2", mi2, 8'h77);
      check_val("coin_tx_empty", tx_empty, 1'b1);
      check_val("coin_rx2", rx_data, 8'h4B);
      check_val("coin_full", rx_full, 1'b1);
      check_val("coin_no_ovf", rx_ovf, 1'b0);

      // asynchronous reset mid-frame
      ss_low(1'b0, 8'h00);
      frame(8'hF0, 4, 1'b0, mi);
      #2 rst = 1'b0;
      #1;
      check_val("arst_busy", busy, 1'b0);
      check_val("arst_rx_full", rx_full, 1'b0);
      check_val("arst_rx_data", rx_data, 8'h00);
      tick(2);
      rst = 1'b1;
      ss_n_in = 1'b1;
      tick(4);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/spi_slave_core.md
Name: spi_slave_core

Overview:
- Slave-side SPI transfer engine. It is the receiving/responding end of the link whose mode bits come from the SPI control register.
- Consumes SPE/MSTR/CPOL/CPHA/LSBFE, samples external SCK/MOSI/SS_n in the clk domain, shifts 8-bit frames in and out, and drives MISO.
- Sits between the pad ring and the SPI data/status registers: rx byte + full/overrun flags upward, one-deep tx buffer downward.

Parameters:
- DATA_W, 8, frame width in bits.
- SYNC_STAGES, 2, synchronizer flops on sck/mosi/ss_n (minimum 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- spe  in  1  SPI enable from control register.
- mstr  in  1  master select; core is active only when 0.
- cpol  in  1  clock polarity (idle level of SCK).
- cpha  in  1  clock phase.
- lsbfe  in  1  1 = LSB first, 0 = MSB first.
- tx_data  in  DATA_W  byte for the next frame.
- tx_load  in  1  1-clk strobe, write tx_data into tx buffer.
- rx_read  in  1  1-clk strobe, host consumed rx_data.
- sck_in  in  1  external SCK, asynchronous.
- mosi_in  in  1  external MOSI, asynchronous.
- ss_n_in  in  1  external slave select, active-low, asynchronous.
- miso_out  out  1  serial data out.
- miso_oe  out  1  MISO output enable.
- rx_data  out  DATA_W  last completed received byte.
- rx_full  out  1  rx_data holds an unread byte.
- rx_ovf  out  1  sticky overrun flag.
- tx_empty  out  1  tx buffer free.
- busy  out  1  frame in progress.

Behaviour:
- Reset values: miso_out=0, miso_oe=0, rx_data=0, rx_full=0, rx_ovf=0, tx_empty=1, busy=0. Shift register, bit counter and tx buffer all clear; state IDLE.
- enabled = spe & ~mstr.
- Input capture: sck, mosi and ss_n pass through SYNC_STAGES flops, then edge detection against the previous synced value. A pad edge is acted on SYNC_STAGES+1 clk later.
- Timing constraint: SCK high and low times are each ≥ 4 clk. ss_n fall to first SCK edge is ≥ 4 clk.
- Edge definitions:
  - leading edge = SCK leaving its cpol level; trailing edge = SCK returning to it.
  - sample edge = leading if cpha=0, trailing if cpha=1.
  - shift edge = the other edge.
- States: IDLE, ACTIVE.
- IDLE -> ACTIVE on synced ss_n falling while enabled. On this transition:
  - capture cpol/cpha/lsbfe; changes to them while ACTIVE are ignored;
  - load the shift register from the tx buffer (0x00 if tx_empty=1) and set tx_empty=1;
  - clear bit_cnt; set busy=1.
- A tx_load in the same clk as the IDLE->ACTIVE load writes the buffer for the next frame, leaving tx_empty=0.
- MISO drive:
  - cpha=0: first bit is driven on MISO in the load cycle.
  - cpha=1: first bit is driven on the first shift (leading) edge.
  - Bit order follows the captured lsbfe.
- On each sample edge: shift the synced MOSI into the rx shift register and increment bit_cnt.
- On each shift edge: advance MISO to the next bit. The cpha=0 trailing edge after bit 8 is ignored.
- Frame complete = sample edge that makes bit_cnt reach DATA_W. In the next clk:
  - if rx_full=0: rx_data <= received byte, rx_full=1;
  - else: rx_ovf=1 and the new byte is discarded (rx_data unchanged).
- After frame complete with ss_n still low:
  - reload from the tx buffer (same rules as the ss_n-fall load) and clear bit_cnt;
  - stay ACTIVE, ready for back-to-back frames.
- rx_read clears rx_full the following clk. rx_read coincident with a frame completion: the completion wins; rx_full stays 1 and rx_data updates.
- rx_ovf clears only on rst or when spe goes low.
- ACTIVE -> IDLE when ss_n rises or enabled drops:
  - abort immediately; a partial frame is discarded with no rx_full change;
  - bit_cnt=0, busy=0, miso_oe=0.
- Status of frames: busy=1 while ACTIVE; miso_oe = enabled & ~ss_n_sync; miso_out=0 whenever miso_oe=0.
- rst asserted mid-frame returns every register to its reset value asynchronously.

Decomposition:
- spi_pkg:
  - state enum (IDLE, ACTIVE);
  - DATA_W default;
  - localparams for cpha/cpol edge selection.
- Sub-module spi_sync:
  - parameterized-width N-flop synchronizer, async active-low reset, reset value 1 for ss_n and 0 for others (per-bit reset parameter);
  - one instance covers sck/mosi/ss_n.

Test Plan:
- Mode 0 (cpol=0,cpha=0,lsbfe=0), tx_load 0xA5, master sends 0x3C at SCK=clk/8 -> MISO bits 1,0,1,0,0,1,0,1; rx_data=0x3C, rx_full=1, tx_empty=1 after load.
- Mode 3 (cpol=1,cpha=1,lsbfe=1), tx 0x81, master sends 0x0F -> MISO LSB first 1,0,0,0,0,0,0,1 on leading edges; rx_data=0x0F.
- Back-to-back: ss_n held low for 2 frames, 0x11 then 0x22 sent, no rx_read -> rx_data=0x11, rx_ovf=1; second frame MISO=0x00 (tx empty).
- Abort: ss_n raised after 5 SCK sample edges -> rx_full unchanged, busy=0 within SYNC_STAGES+2 clk; next frame 0x5A received correctly.
- mstr=1 or spe=0 with ss_n low and SCK toggling -> miso_oe=0, no rx_full; spe drop mid-frame aborts and clears rx_ovf.
- Coincidence: tx_load 0x77 in the ss_n-fall load cycle with tx_empty=1 -> frame 1 sends 0x00, frame 2 sends 0x77; rx_read coincident with completion -> rx_full stays 1, no overrun.
